popcount_seq: RTL and testbench

Parametrised multi-cycle population counter, generalising the fixed 8-bit ones counter to WIDTH-bit words. It processes CHUNK bits per clock and uses valid/ready handshakes on both the input and output sides. A mode input selects counting ones or zeros. It sits between a register/operand source and any consumer needing a bit count, such as a normaliser or match scorer.

---
 rtl/popcount_seq.sv | 130 +++++++++++++
 tb/tb_popcount_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/popcount_seq.sv
// Multi-cycle population counter: counts ones (or zeros) of a WIDTH-bit word, CHUNK bits per clock.
// Optional macro POPCOUNT_PARITY_EN adds out_parity, the XOR reduction of the captured word.
module popcount_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_count,
`ifdef POPCOUNT_PARITY_EN
  output logic                         out_parity,
`endif
  output logic                         busy
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int NBEATS = WIDTH / CHUNK;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [CW-1:0]     count_q, count_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     sum;
`ifdef POPCOUNT_PARITY_EN
  logic              parity_q, parity_d;
`endif

  function automatic logic [CW-1:0] chunk_pop(input logic [CHUNK-1:0] bits);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) begin
      n = n + CW'(bits[i]);
    end
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    count_d = count_q;
    valid_d = valid_q;
`ifdef POPCOUNT_PARITY_EN
    parity_d = parity_q;
`endif
    // CW-wide sum so an all-ones word reaches WIDTH without wrapping
    sum = acc_q + chunk_pop(shift_q[CHUNK-1:0]);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_mode ? ~in_data : in_data;
          acc_d   = '0;
          beat_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d   = sum;
        shift_d = shift_q >> CHUNK;
        beat_d  = beat_q + 1'b1;
        if (beat_q == BW'(NBEATS - 1)) begin
          state_d = DONE;
          count_d = sum;
          valid_d = 1'b1;
`ifdef POPCOUNT_PARITY_EN
          // parity of the captured word is the LSB of its bit count
          parity_d = sum[0];
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
`ifdef POPCOUNT_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      count_q <= count_d;
      valid_q <= valid_d;
`ifdef POPCOUNT_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_count = count_q;
`ifdef POPCOUNT_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_popcount_seq.sv
// Directed bench for popcount_seq: 32/8, 8/8 and 12/4 configurations sharing one clock and reset.
module tb_popcount_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 32-bit, 8 per beat
  logic        iv32 = 0, ir32, im32 = 0, ov32, or32 = 0, b32;
  logic [31:0] id32 = 0;
  logic [5:0]  c32;
  // 8-bit, single beat
  logic        iv8 = 0, ir8, im8 = 0, ov8, or8 = 0, b8;
  logic [7:0]  id8 = 0;
  logic [3:0]  c8;
  // 12-bit, 4 per beat
  logic        iv12 = 0, ir12, im12 = 0, ov12, or12 = 0, b12;
  logic [11:0] id12 = 0;
  logic [3:0]  c12;
`ifdef POPCOUNT_PARITY_EN
  logic        p32, p8, p12;
`endif

  popcount_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_mode(im32),
    .out_valid(ov32), .out_ready(or32), .out_count(c32),
`ifdef POPCOUNT_PARITY_EN
    .out_parity(p32),
`endif
    .busy(b32));

  popcount_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_mode(im8),
    .out_valid(ov8), .out_ready(or8), .out_count(c8),
`ifdef POPCOUNT_PARITY_EN
    .out_parity(p8),
`endif
    .busy(b8));

  popcount_seq #(.WIDTH(12), .CHUNK(4)) dut12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .in_data(id12), .in_mode(im12),
    .out_valid(ov12), .out_ready(or12), .out_count(c12),
`ifdef POPCOUNT_PARITY_EN
    .out_parity(p12),
`endif
    .busy(b12));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a word, wait for acceptance, then scramble inputs after the accepting edge.
  task automatic start32(input logic [31:0] d, input logic m);
    int t;
    @(negedge clk);
    iv32 = 1'b1; id32 = d; im32 = m;
    t = 0;
    while (!ir32 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 32'(ir32), 32'd1);
    @(posedge clk);
    #1;
    iv32 = 1'b0; id32 = ~d; im32 = ~m;
  endtask

  // n = number of negedges after acceptance before out_valid is seen (expect NBEATS).
  task automatic wait_valid32(output int n, output logic busy0);
    n = 0;
    @(negedge clk);
    busy0 = b32;
    while (!ov32 && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pop32(input logic [5:0] exp);
    or32 = 1'b1;
    @(posedge clk);
    #1;
    or32 = 1'b0;
    @(negedge clk);
    check("pop_valid", 32'(ov32), 32'd0);
    check("pop_ready", 32'(ir32), 32'd1);
    check("pop_busy", 32'(b32), 32'd0);
    check("pop_retain", 32'(c32), 32'(exp));
  endtask

  task automatic run32(input logic [31:0] d, input logic m, input logic [5:0] exp);
    int   n;
    logic bz;
    start32(d, m);
    wait_valid32(n, bz);
    check("lat32", n, 32'd4);
    check("busy_acc", 32'(bz), 32'd1);
    check("count32", 32'(c32), 32'(exp));
`ifdef POPCOUNT_PARITY_EN
    check("parity32", 32'(p32), 32'(exp[0]));
`endif
    pop32(exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    logic bz;
    logic seen;

    repeat (2) @(negedge clk);
    check("rst_ready32", 32'(ir32), 32'd0);
    check("rst_ready8", 32'(ir8), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(ov32), 32'd0);
    check("rst_count", 32'(c32), 32'd0);
    check("rst_busy", 32'(b32), 32'd0);
    check("idle_ready", 32'(ir32), 32'd1);

    run32(32'hFFFF_FFFF, 1'b0, 6'd32);
    run32(32'h0000_0000, 1'b0, 6'd0);
    run32(32'h0000_0000, 1'b1, 6'd32);
    run32(32'h0000_000F, 1'b1, 6'd28);

    // Result held in DONE while the consumer stalls and a new word is offered
    start32(32'hA5A5_A5A5, 1'b0);
    wait_valid32(n, bz);
    check("hold_lat", n, 32'd4);
    iv32 = 1'b1; id32 = 32'hFFFF_FFFF; im32 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(ov32), 32'd1);
      check("hold_count", 32'(c32), 32'd16);
      check("hold_ready", 32'(ir32), 32'd0);
    end
    iv32 = 1'b0;
    pop32(6'd16);

    // Reset during beat 2 discards the word
    start32(32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(ir32), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    check("midrst_novalid", 32'(seen), 32'd0);
    check("midrst_count", 32'(c32), 32'd0);
    check("midrst_busy", 32'(b32), 32'd0);
    run32(32'h0000_0101, 1'b0, 6'd2);

    // WIDTH == CHUNK: single ACC cycle
    @(negedge clk);
    check("w8_ready", 32'(ir8), 32'd1);
    iv8 = 1'b1; id8 = 8'hB7; im8 = 1'b0;
    @(posedge clk);
    #1;
    iv8 = 1'b0; id8 = 8'h00;
    @(negedge clk);
    check("w8_early", 32'(ov8), 32'd0);
    @(negedge clk);
    check("w8_valid", 32'(ov8), 32'd1);
    check("w8_count", 32'(c8), 32'd6);
    or8 = 1'b1;
    @(posedge clk);
    #1;
    or8 = 1'b0;

    // Full-count case at CW = 4
    @(negedge clk);
    check("w12_ready", 32'(ir12), 32'd1);
    iv12 = 1'b1; id12 = 12'hFFF; im12 = 1'b0;
    @(posedge clk);
    #1;
    iv12 = 1'b0; id12 = 12'h000;
    repeat (3) @(negedge clk);
    check("w12_early", 32'(ov12), 32'd0);
    @(negedge clk);
    check("w12_valid", 32'(ov12), 32'd1);
    check("w12_count", 32'(c12), 32'd12);
    or12 = 1'b1;
    @(posedge clk);
    #1;
    or12 = 1'b0;

`ifdef POPCOUNT_PARITY_EN
    run32(32'h0000_0007, 1'b0, 6'd3);
    run32(32'h0000_0003, 1'b0, 6'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
